// File: rtl/axis_skid_fifo.sv
// DEPTH-entry AXI-Stream elastic buffer with first-word fall-through, TLAST passthrough,
// occupancy/almost-full reporting and synchronous flush. Handshake outputs decode registered count.
module axis_skid_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter bit          OPT_LOWPOWER = 1'b1,
  parameter int unsigned AF_THRESH    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_axis_valid,
  input  logic [DATA_WIDTH-1:0]      s_axis_data,
  input  logic                       s_axis_last,
  output logic                       s_axis_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_data,
  output logic                       m_axis_last,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     count_q, count_d;
  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [DATA_WIDTH:0] rd_word;
  logic                push, pop;

  // Ready/valid come only from registered count, so m_axis_ready never reaches s_axis_ready.
  assign s_axis_ready = (count_q != LvlW'(DEPTH));
  assign m_axis_valid = (count_q != '0);
  assign level        = count_q;
  assign almost_full  = (count_q >= LvlW'(AF_THRESH));

  assign push = s_axis_valid & s_axis_ready;
  assign pop  = m_axis_valid & m_axis_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush discards any handshake that coincides with it.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + LvlW'(1);
        2'b01:   count_d = count_q - LvlW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {s_axis_last, s_axis_data};
  end

  always_comb begin
    rd_word = mem_q[rd_ptr_q];
    if (OPT_LOWPOWER && !m_axis_valid) rd_word = '0;
  end

  assign m_axis_last = rd_word[DATA_WIDTH];
  assign m_axis_data = rd_word[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_skid_fifo.sv
// Randomised bench for axis_skid_fifo, checked against a queue-based model of the buffer.
module tb_axis_skid_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          s_axis_valid;
  logic [DW-1:0] s_axis_data;
  logic          s_axis_last;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [2:0]    level;
  logic          almost_full;

  axis_skid_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .OPT_LOWPOWER(1'b1),
    .AF_THRESH   (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .s_axis_valid(s_axis_valid),
    .s_axis_data (s_axis_data),
    .s_axis_last (s_axis_last),
    .s_axis_ready(s_axis_ready),
    .m_axis_data (m_axis_data),
    .m_axis_last (m_axis_last),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] model_q[$];  // {last, data}, head = oldest beat
  logic [DW:0] out_log[$];  // beats popped by the consumer
  bit          accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned n = model_q.size();
    logic [DW:0] head = (n != 0) ? model_q[0] : '0;
    check({tag, ".ready"}, 32'(s_axis_ready), 32'(n != DEPTH));
    check({tag, ".valid"}, 32'(m_axis_valid), 32'(n != 0));
    check({tag, ".data"},  32'(m_axis_data),  32'(head[DW-1:0]));
    check({tag, ".last"},  32'(m_axis_last),  32'(head[DW]));
    check({tag, ".level"}, 32'(level),        n);
    check({tag, ".af"},    32'(almost_full),  32'(n >= AF));
  endtask

  // Check, advance the model by one clock, then sit 1 ns past the edge.
  task automatic step(input string tag);
    bit exp_ready, exp_valid, do_push, do_pop;
    check_outputs(tag);
    exp_ready = (model_q.size() != DEPTH);
    exp_valid = (model_q.size() != 0);
    do_push   = s_axis_valid && exp_ready;
    do_pop    = exp_valid && m_axis_ready;
    accepted  = do_push && !flush;
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop) out_log.push_back(model_q.pop_front());
      if (do_push) model_q.push_back({s_axis_last, s_axis_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l, input logic rdy);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    m_axis_ready = rdy;
    step("push");
    s_axis_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    s_axis_valid = 1'b0;
    m_axis_ready = rdy;
    for (int i = 0; i < n; i++) step("idle");
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
    m_axis_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // Three beats with consumer stalled.
    push_beat(8'h11, 1'b0, 1'b0);
    push_beat(8'h22, 1'b0, 1'b0);
    push_beat(8'h33, 1'b0, 1'b0);
    check("t1.level", 32'(level), 3);
    check("t1.af", 32'(almost_full), 1);
    check("t1.ready", 32'(s_axis_ready), 1);
    check("t1.head", 32'(m_axis_data), 32'h11);
    flush = 1'b1; step("t1.flush"); flush = 1'b0;

    // Fill to full, hold a fifth beat, then drain.
    out_log.delete();
    for (int i = 0; i < 4; i++) push_beat(8'hA0 + 8'(i), 1'b0, 1'b0);
    check("t2.full_ready", 32'(s_axis_ready), 0);
    s_axis_valid = 1'b1; s_axis_data = 8'hA4; s_axis_last = 1'b0; m_axis_ready = 1'b0;
    step("t2.hold"); step("t2.hold");
    m_axis_ready = 1'b1;
    for (int i = 0; i < 10 && s_axis_valid; i++) begin
      step("t2.drain");
      if (accepted) s_axis_valid = 1'b0;
    end
    idle_cycles(6, 1'b1);
    check("t2.count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      check("t2.order", 32'(out_log[i][DW-1:0]), 32'hA0 + i);

    // Back-to-back stream: one beat per cycle, level pinned at 1.
    m_axis_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(i); s_axis_last = 1'b0;
      step("t3.stream");
      check("t3.level", 32'(level), 1);
    end
    idle_cycles(2, 1'b1);

    // Random valid gaps and back-pressure; last on every 8th beat.
    begin
      int beat = 0;
      out_log.delete();
      s_axis_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (!s_axis_valid) begin
          s_axis_valid = ($urandom_range(0, 3) != 0);
          s_axis_data  = 8'($urandom);
          s_axis_last  = ((beat % 8) == 7);
        end
        m_axis_ready = ($urandom_range(0, 2) != 0);
        step("t4.rand");
        if (accepted) begin
          beat++;
          s_axis_valid = 1'b0;
        end
      end
      idle_cycles(6, 1'b1);
      check("t4.beats", out_log.size(), beat);
      for (int i = 0; i < out_log.size(); i++)
        check("t4.last", 32'(out_log[i][DW]), 32'((i % 8) == 7));
    end

    // Ten beats across the pointer wrap with alternating consumer ready.
    for (int i = 0; i < 10; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'hC0 + 8'(i); s_axis_last = 1'b0;
      m_axis_ready = i[0];
      step("t5.wrap");
      while (!accepted) begin
        m_axis_ready = ~m_axis_ready;
        step("t5.wrap");
      end
    end
    idle_cycles(6, 1'b1);

    // Flush with a coincident push: 0x55 must never appear.
    out_log.delete();
    for (int i = 0; i < 3; i++) push_beat(8'h60 + 8'(i), 1'b0, 1'b0);
    flush = 1'b1; s_axis_valid = 1'b1; s_axis_data = 8'h55;
    step("t6.flush");
    flush = 1'b0; s_axis_valid = 1'b0;
    check("t6.level", 32'(level), 0);
    check("t6.valid", 32'(m_axis_valid), 0);
    check("t6.ready", 32'(s_axis_ready), 1);
    idle_cycles(4, 1'b1);
    check("t6.no_out", out_log.size(), 0);

    // Asynchronous reset between edges.
    push_beat(8'h81, 1'b1, 1'b0);
    push_beat(8'h82, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    model_q.delete();
    check("t7.valid", 32'(m_axis_valid), 0);
    check("t7.data", 32'(m_axis_data), 0);
    check("t7.level", 32'(level), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_log.delete();
    push_beat(8'h77, 1'b0, 1'b0);
    idle_cycles(3, 1'b1);
    check("t7.first_cnt", out_log.size(), 1);
    if (out_log.size() != 0) check("t7.first", 32'(out_log[0][DW-1:0]), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_skid_fifo.md
Name: axis_skid_fifo

Overview:
- Parametrised successor to the team's 2-entry AXI-Stream skid buffer.
- Provides a DEPTH-entry elastic buffer with TLAST passthrough, occupancy reporting, an almost-full flag and a synchronous flush.
- s_axis_ready is a pure function of registered state, so no combinational path exists from m_axis_ready to s_axis_ready.
- Sits between stream producers and consumers wherever back-pressure timing must be broken and bursts absorbed.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 4, number of storage entries; power of two, at least 2.
- OPT_LOWPOWER, 1, when 1, m_axis_data and m_axis_last read 0 whenever m_axis_valid=0.
- AF_THRESH, 3, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all stored beats.
- s_axis_valid  in  1  upstream beat valid.
- s_axis_data  in  DATA_WIDTH  upstream payload.
- s_axis_last  in  1  upstream end-of-packet marker.
- s_axis_ready  out  1  buffer can accept a beat.
- m_axis_data  out  DATA_WIDTH  downstream payload.
- m_axis_last  out  1  downstream end-of-packet marker.
- m_axis_valid  out  1  downstream beat valid.
- m_axis_ready  in  1  downstream accepts beat.
- level  out  $clog2(DEPTH+1)  current number of stored beats.
- almost_full  out  1  level >= AF_THRESH.

Behaviour:
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0. Outputs: s_axis_ready=1, m_axis_valid=0, m_axis_data=0, m_axis_last=0, level=0, almost_full=0. Memory contents are not reset.
- Handshakes: push = s_axis_valid & s_axis_ready; pop = m_axis_valid & m_axis_ready. Both follow standard AXI-S rules.
- Storage: circular buffer with ptr width $clog2(DEPTH); pointers wrap modulo DEPTH (DEPTH-1 -> 0). Each entry stores {last, data}.
- Push: writes mem[wr_ptr]; wr_ptr increments.
- Pop: rd_ptr increments.
- count (equal to level):
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance.
- s_axis_ready = (count != DEPTH), decoded from registered count only.
- m_axis_valid = (count != 0).
- m_axis_data/m_axis_last = mem[rd_ptr] when m_axis_valid. When m_axis_valid=0: 0 if OPT_LOWPOWER=1, otherwise don't-care.
- Latency: a beat pushed at edge N is presented on m_axis at N+1 (first-word fall-through). Minimum latency is 1 cycle; there is no combinational input-to-output path.
- Throughput: 1 beat/cycle sustained when m_axis_ready=1 and the FIFO is not empty.
- Full (count=DEPTH): s_axis_ready=0 and no push occurs. A pop in this cycle makes ready=1 on the next cycle, not the same cycle.
- Empty (count=0): m_axis_valid=0. A simultaneous push/pop cannot occur.
- Producer stability: the producer holds s_axis_valid/data/last stable while ready=0. The buffer never drops or duplicates a beat.
- Flush:
  - Next edge: pointers and count go to 0; any push or pop in that cycle is discarded.
  - Next cycle: m_axis_valid=0, s_axis_ready=1.
  - Reset has priority over flush.
- almost_full = (count >= AF_THRESH), registered-state decode with no extra latency.
- Reset asserted mid-transfer: all state clears immediately; in-flight beats are lost and outputs take reset values asynchronously.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with m_axis_ready=0 -> level=3, almost_full=1, s_axis_ready=1, m_axis_data=0x11 valid.
- Push 4 beats 0xA0..0xA3 with m_axis_ready=0 (DEPTH=4) -> s_axis_ready=0 after the 4th edge; a 5th beat 0xA4 is held. Set m_axis_ready=1 -> output order 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 with no loss or duplicates.
- Continuous stream 0..255 with m_axis_ready=1 -> one beat/cycle, output lags input by exactly 1 cycle, and level stays at 1. Repeat with randomised m_axis_ready and randomised s_axis_valid gaps -> data order preserved; s_axis_last arriving on every 8th beat is seen on m_axis_last for exactly those beats.
- Drive 10 beats so the pointers wrap past DEPTH-1 while alternating m_axis_ready -> data matches the scoreboard across the wrap boundary.
- Fill 3 beats, then pulse flush for one cycle together with s_axis_valid=1 (data 0x55) -> next cycle level=0, m_axis_valid=0, and 0x55 never appears on the output.
- Fill 2 beats, assert reset between clock edges -> m_axis_valid=0, m_axis_data=0 and level=0 immediately, before the next edge. After release the buffer accepts 0x77, and 0x77 is the first beat out.
